// File: rtl/spi_accel_pkg.sv
// Shared opcodes, register addresses and FSM encodings for the SPI accelerometer responder.
package spi_accel_pkg;

    localparam logic [7:0] OP_REG_READ  = 8'h0B;
    localparam logic [7:0] OP_REG_WRITE = 8'h0A;

    localparam logic [7:0] ADDR_DEVID     = 8'h00;
    localparam logic [7:0] ADDR_DEVID_MST = 8'h01;
    localparam logic [7:0] ADDR_PARTID    = 8'h02;
    localparam logic [7:0] ADDR_XDATA     = 8'h09;
    localparam logic [7:0] ADDR_YDATA     = 8'h0A;
    localparam logic [7:0] ADDR_ZDATA     = 8'h0B;
    localparam logic [7:0] ADDR_RW_BASE   = 8'h20;
    localparam logic [7:0] ADDR_POWER_CTL = 8'h2D;

    localparam logic [7:0] RW_LO = 8'h20;
    localparam logic [7:0] RW_HI = 8'h2F;

    localparam logic [7:0] DEVID_MST_VAL = 8'h1D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    function automatic logic in_rw_window(input logic [7:0] a);
        return (a >= RW_LO) && (a <= RW_HI);
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for an asynchronous SPI line, with rise/fall strobes on the synchronized level.
module spi_input_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-0 slave answering the accelerometer register read/write command set from the CLK domain.
// Optional error counter output ERR_CNT is built when SPI_ACCEL_RESPONDER_ERR_CNT_EN is defined.
//   state     | meaning
//   ST_IDLE   | CS high, waiting for CS fall
//   ST_CMD    | shifting in instruction byte
//   ST_ADDR   | shifting in register address
//   ST_WDATA  | committing write bytes, auto-increment
//   ST_RDATA  | shifting out map bytes on SCLK fall
//   ST_IGNORE | unknown instruction, wait for CS high
module spi_accel_responder
    import spi_accel_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID       = 8'hAD,
    parameter logic [7:0] PARTID      = 8'hF2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SCLK,
    input  logic       CS,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_OE,
    input  logic       SENSOR_LOAD,
    input  logic [7:0] SENSOR_X,
    input  logic [7:0] SENSOR_Y,
    input  logic [7:0] SENSOR_Z,
    output logic       REG_WR,
    output logic [7:0] REG_WR_ADDR,
    output logic [7:0] REG_WR_DATA,
    output logic       MEASURE_ON
`ifdef SPI_ACCEL_RESPONDER_ERR_CNT_EN
    ,
    output logic [7:0] ERR_CNT
`endif
);

    logic unused_sclk_level;
    logic sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_lvl;

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .CLK   (CLK),
        .RESET (RESET),
        .din   (SCLK),
        .level (unused_sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // CS idles high, so its synchronizer resets high to avoid a phantom select.
    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .CLK   (CLK),
        .RESET (RESET),
        .din   (CS),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    always_ff @(posedge CLK) begin
        if (RESET) mosi_chain <= '0;
        else       mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], MOSI};
    end
    assign mosi_lvl = mosi_chain[SYNC_STAGES-1];

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic [7:0] addr;
    logic [7:0] rd_shift;
    logic       is_read;
    logic [7:0] regs [16];
    logic [7:0] shadow_x, shadow_y, shadow_z;
    logic [7:0] pend_x, pend_y, pend_z;
    logic       load_pending;

    logic       sclk_rise_v, sclk_fall_v, byte_done;
    logic [7:0] byte_in, addr_next;

    assign sclk_rise_v = sclk_rise & ~cs_lvl;
    assign sclk_fall_v = sclk_fall & ~cs_lvl;
    assign byte_in     = {shift_in, mosi_lvl};
    assign byte_done   = sclk_rise_v && (bit_cnt == 3'd7);
    assign addr_next   = addr + 8'd1;

    function automatic logic [7:0] map_read(input logic [7:0] a);
        logic [7:0] v;
        case (a)
            ADDR_DEVID:     v = DEVID;
            ADDR_DEVID_MST: v = DEVID_MST_VAL;
            ADDR_PARTID:    v = PARTID;
            ADDR_XDATA:     v = shadow_x;
            ADDR_YDATA:     v = shadow_y;
            ADDR_ZDATA:     v = shadow_z;
            default:        v = in_rw_window(a) ? regs[a[3:0]] : 8'h00;
        endcase
        return v;
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            shift_in    <= 7'd0;
            addr        <= 8'h00;
            rd_shift    <= 8'h00;
            is_read     <= 1'b0;
            MISO        <= 1'b0;
            MISO_OE     <= 1'b0;
            REG_WR      <= 1'b0;
            REG_WR_ADDR <= 8'h00;
            REG_WR_DATA <= 8'h00;
            MEASURE_ON  <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
`ifdef SPI_ACCEL_RESPONDER_ERR_CNT_EN
            ERR_CNT     <= 8'h00;
`endif
        end else begin
            REG_WR <= 1'b0;
            if (cs_rise) begin
                // A partially shifted byte is dropped here without any commit.
                state   <= ST_IDLE;
                bit_cnt <= 3'd0;
                MISO    <= 1'b0;
                MISO_OE <= 1'b0;
`ifdef SPI_ACCEL_RESPONDER_ERR_CNT_EN
                if (bit_cnt != 3'd0 && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
`endif
            end else if (cs_fall) begin
                state   <= ST_CMD;
                bit_cnt <= 3'd0;
            end else if (state != ST_IDLE) begin
                if (sclk_rise_v) begin
                    shift_in <= byte_in[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    case (state)
                        ST_CMD: begin
                            if (byte_in == OP_REG_READ) begin
                                state   <= ST_ADDR;
                                is_read <= 1'b1;
                            end else if (byte_in == OP_REG_WRITE) begin
                                state   <= ST_ADDR;
                                is_read <= 1'b0;
                            end else begin
                                state <= ST_IGNORE;
`ifdef SPI_ACCEL_RESPONDER_ERR_CNT_EN
                                if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
`endif
                            end
                        end
                        ST_ADDR: begin
                            addr <= byte_in;
                            if (is_read) begin
                                state    <= ST_RDATA;
                                rd_shift <= map_read(byte_in);
                                MISO_OE  <= 1'b1;
                            end else begin
                                state <= ST_WDATA;
                            end
                        end
                        ST_WDATA: begin
                            if (in_rw_window(addr)) begin
                                regs[addr[3:0]] <= byte_in;
                                REG_WR          <= 1'b1;
                                REG_WR_ADDR     <= addr;
                                REG_WR_DATA     <= byte_in;
                            end
                            addr <= addr_next;
                        end
                        ST_RDATA: begin
                            addr     <= addr_next;
                            rd_shift <= map_read(addr_next);
                        end
                        default: ;
                    endcase
                end
                if (sclk_fall_v && state == ST_RDATA) begin
                    MISO     <= rd_shift[7];
                    rd_shift <= {rd_shift[6:0], 1'b0};
                end
            end
            MEASURE_ON <= regs[ADDR_POWER_CTL[3:0]][1];
        end
    end

    // Loads during a transaction wait for CS high so a burst never mixes old and new samples.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            shadow_x     <= 8'h00;
            shadow_y     <= 8'h00;
            shadow_z     <= 8'h00;
            pend_x       <= 8'h00;
            pend_y       <= 8'h00;
            pend_z       <= 8'h00;
            load_pending <= 1'b0;
        end else begin
            if (cs_rise && load_pending) begin
                shadow_x     <= pend_x;
                shadow_y     <= pend_y;
                shadow_z     <= pend_z;
                load_pending <= 1'b0;
            end
            if (SENSOR_LOAD) begin
                if (cs_lvl) begin
                    shadow_x <= SENSOR_X;
                    shadow_y <= SENSOR_Y;
                    shadow_z <= SENSOR_Z;
                end else begin
                    pend_x       <= SENSOR_X;
                    pend_y       <= SENSOR_Y;
                    pend_z       <= SENSOR_Z;
                    load_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_accel_responder.sv
// Directed self-checking bench for spi_accel_responder acting as an SPI mode-0 master.
module tb_spi_accel_responder;

    localparam int HALF = 6;

    logic       CLK = 1'b0;
    logic       RESET, SCLK, CS, MOSI;
    logic       MISO, MISO_OE;
    logic       SENSOR_LOAD;
    logic [7:0] SENSOR_X, SENSOR_Y, SENSOR_Z;
    logic       REG_WR;
    logic [7:0] REG_WR_ADDR, REG_WR_DATA;
    logic       MEASURE_ON;
`ifdef SPI_ACCEL_RESPONDER_ERR_CNT_EN
    logic [7:0] ERR_CNT;
`endif

    spi_accel_responder dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SCLK        (SCLK),
        .CS          (CS),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .MISO_OE     (MISO_OE),
        .SENSOR_LOAD (SENSOR_LOAD),
        .SENSOR_X    (SENSOR_X),
        .SENSOR_Y    (SENSOR_Y),
        .SENSOR_Z    (SENSOR_Z),
        .REG_WR      (REG_WR),
        .REG_WR_ADDR (REG_WR_ADDR),
        .REG_WR_DATA (REG_WR_DATA),
        .MEASURE_ON  (MEASURE_ON)
`ifdef SPI_ACCEL_RESPONDER_ERR_CNT_EN
        ,
        .ERR_CNT     (ERR_CNT)
`endif
    );

    always #4 CLK = ~CLK;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         wr_cnt   = 0;
    logic [7:0] wr_addr  = 8'h00;
    logic [7:0] wr_data  = 8'h00;
    logic [7:0] rx;

    always @(negedge CLK) begin
        if (REG_WR === 1'b1) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= REG_WR_ADDR;
            wr_data <= REG_WR_DATA;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            MOSI = tx[i];
            tick(HALF);
            r[i] = MISO;
            SCLK = 1'b1;
            tick(HALF);
            SCLK = 1'b0;
        end
    endtask

    task automatic cs_begin();
        CS = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_end();
        tick(HALF);
        CS = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic start_read(input logic [7:0] a);
        logic [7:0] d;
        cs_begin();
        xfer(8'h0B, 8, d);
        xfer(a, 8, d);
    endtask

    task automatic read_one(input logic [7:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] d;
        start_read(a);
        xfer(8'h00, 8, d);
        check(tag, d, exp);
        cs_end();
    endtask

    task automatic write_one(input logic [7:0] a, input logic [7:0] data);
        logic [7:0] d;
        cs_begin();
        xfer(8'h0A, 8, d);
        xfer(a, 8, d);
        xfer(data, 8, d);
        cs_end();
    endtask

    task automatic sensor_pulse();
        SENSOR_LOAD = 1'b1;
        tick(1);
        SENSOR_LOAD = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0;
        SENSOR_LOAD = 1'b0; SENSOR_X = 8'h00; SENSOR_Y = 8'h00; SENSOR_Z = 8'h00;
        tick(5);
        RESET = 1'b0;
        tick(2);

        check("rst_miso", {7'd0, MISO}, 8'h00);
        check("rst_oe", {7'd0, MISO_OE}, 8'h00);
        check("rst_reg_wr", {7'd0, REG_WR}, 8'h00);
        check("rst_wr_addr", REG_WR_ADDR, 8'h00);
        check("rst_wr_data", REG_WR_DATA, 8'h00);
        check("rst_measure", {7'd0, MEASURE_ON}, 8'h00);
`ifdef SPI_ACCEL_RESPONDER_ERR_CNT_EN
        check("rst_err_cnt", ERR_CNT, 8'h00);
`endif

        // ID burst from 0x00; MISO_OE only during data bytes
        cs_begin();
        xfer(8'h0B, 8, rx);
        check("oe_cmd", {7'd0, MISO_OE}, 8'h00);
        xfer(8'h00, 8, rx);
        tick(2);
        check("oe_data", {7'd0, MISO_OE}, 8'h01);
        xfer(8'hFF, 8, rx); check("rd_devid", rx, 8'hAD);
        xfer(8'hFF, 8, rx); check("rd_devid_mst", rx, 8'h1D);
        xfer(8'hFF, 8, rx); check("rd_partid", rx, 8'hF2);
        cs_end();
        check("oe_idle", {7'd0, MISO_OE}, 8'h00);
        check("miso_idle", {7'd0, MISO}, 8'h00);

        // shadow capture with CS high
        SENSOR_X = 8'h5A; SENSOR_Y = 8'h3C; SENSOR_Z = 8'hC3;
        sensor_pulse();
        tick(3);
        start_read(8'h09);
        xfer(8'h00, 8, rx); check("rd_x", rx, 8'h5A);
        xfer(8'h00, 8, rx); check("rd_y", rx, 8'h3C);
        xfer(8'h00, 8, rx); check("rd_z", rx, 8'hC3);
        cs_end();

        // write to POWER_CTL
        write_one(8'h2D, 8'h0A);
        check("wr_cnt_2d", 8'(wr_cnt), 8'd1);
        check("wr_addr_2d", wr_addr, 8'h2D);
        check("wr_data_2d", wr_data, 8'h0A);
        check("measure_on", {7'd0, MEASURE_ON}, 8'h01);
        read_one(8'h2D, 8'h0A, "rb_2d");

        // write to read-only address
        write_one(8'h00, 8'h55);
        check("wr_cnt_ro", 8'(wr_cnt), 8'd1);
        read_one(8'h00, 8'hAD, "rb_devid");

        // burst write crossing the window top: 0x30 is dropped
        cs_begin();
        xfer(8'h0A, 8, rx);
        xfer(8'h2E, 8, rx);
        xfer(8'h11, 8, rx);
        xfer(8'h22, 8, rx);
        xfer(8'h33, 8, rx);
        cs_end();
        check("wr_cnt_burst", 8'(wr_cnt), 8'd3);
        check("wr_addr_burst", wr_addr, 8'h2F);
        check("wr_data_burst", wr_data, 8'h22);
        start_read(8'h2E);
        xfer(8'h00, 8, rx); check("rb_2e", rx, 8'h11);
        xfer(8'h00, 8, rx); check("rb_2f", rx, 8'h22);
        xfer(8'h00, 8, rx); check("rb_30", rx, 8'h00);
        cs_end();

        // address wrap on burst read
        start_read(8'hFF);
        xfer(8'h00, 8, rx); check("rd_ff", rx, 8'h00);
        xfer(8'h00, 8, rx); check("rd_wrap_00", rx, 8'hAD);
        cs_end();

        // aborted write data byte after 5 bits
        cs_begin();
        xfer(8'h0A, 8, rx);
        xfer(8'h20, 8, rx);
        xfer(8'hFF, 5, rx);
        cs_end();
        check("wr_cnt_abort", 8'(wr_cnt), 8'd3);
        read_one(8'h20, 8'h00, "rb_abort_20");
`ifdef SPI_ACCEL_RESPONDER_ERR_CNT_EN
        check("err_cnt_abort", ERR_CNT, 8'h01);
`endif

        // unknown instruction is ignored
        cs_begin();
        xfer(8'h0C, 8, rx);
        xfer(8'h2D, 8, rx);
        xfer(8'h55, 8, rx);
        cs_end();
        check("wr_cnt_unknown", 8'(wr_cnt), 8'd3);
        read_one(8'h2D, 8'h0A, "rb_unknown_2d");
`ifdef SPI_ACCEL_RESPONDER_ERR_CNT_EN
        check("err_cnt_unknown", ERR_CNT, 8'h02);
`endif

        // sensor load mid-burst is deferred until CS high
        start_read(8'h09);
        xfer(8'h00, 8, rx); check("burst_old_x", rx, 8'h5A);
        SENSOR_X = 8'h11; SENSOR_Y = 8'h77;
        sensor_pulse();
        xfer(8'h00, 8, rx); check("burst_old_y", rx, 8'h3C);
        cs_end();
        start_read(8'h09);
        xfer(8'h00, 8, rx); check("new_x", rx, 8'h11);
        xfer(8'h00, 8, rx); check("new_y", rx, 8'h77);
        cs_end();

        // clear measure bit
        write_one(8'h2D, 8'h00);
        check("wr_cnt_clr", 8'(wr_cnt), 8'd4);
        check("measure_off", {7'd0, MEASURE_ON}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
